// File: rtl/branch_pdt_pkg.sv
// Shared counter encodings, default geometry and FSM states for the branch_pdt predictor.
// Also holds the saturating 2-bit counter step used by every prediction table.
package branch_pdt_pkg;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   localparam int HIST_W_DEF = 10;
   localparam int LIDX_W_DEF = 10;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } pdt_state_e;

   function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic inc);
      logic [1:0] res;
      res = cnt;
      if (inc) begin
         if (cnt != CNT_ST) res = cnt + 2'd1;
      end else begin
         if (cnt != CNT_SNT) res = cnt - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/pdt_table.sv
// 2-bit saturating counter array: combinational read, read-modify-write update, init write.
// Update and read are zero-latency on the read side; writes land at the next clk edge, no back-pressure.
module pdt_table
   import branch_pdt_pkg::*;
#(
   parameter int IDX_W  = 10,
   parameter int INIT_W = 10
) (
   input  logic              clk,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic [1:0]        rd_cnt_o,
   input  logic              upd_en_i,
   input  logic [IDX_W-1:0]  upd_idx_i,
   input  logic              upd_inc_i,
   output logic [1:0]        upd_cnt_o,
   input  logic              init_en_i,
   input  logic [INIT_W-1:0] init_idx_i
);

   localparam int DEPTH = 1 << IDX_W;

   logic [1:0] cnt_q [DEPTH];
   logic       init_hit;

   // A shared init sweep may run past this table's depth; those indices are dropped.
   assign init_hit  = init_en_i && ((init_idx_i >> IDX_W) == '0);

   assign rd_cnt_o  = cnt_q[rd_idx_i];
   assign upd_cnt_o = cnt_q[upd_idx_i];

   always_ff @(posedge clk) begin
      if (init_hit) begin
         cnt_q[init_idx_i[IDX_W-1:0]] <= CNT_WNT;
      end else if (upd_en_i) begin
         cnt_q[upd_idx_i] <= cnt_step(upd_cnt_o, upd_inc_i);
      end
   end

endmodule

// File: rtl/branch_pdt.sv
// Fetch-stage tournament predictor (local/gshare/chooser), build option BPD_TOURNAMENT_EN; lookup is combinational.
// Table and GHR writes land next clk edge; one resolved-branch update accepted per cycle, no back-pressure.
module branch_pdt
   import branch_pdt_pkg::*;
#(
   parameter int HIST_W = HIST_W_DEF,
   parameter int LIDX_W = LIDX_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic [31:0]       if_pc,
   input  logic              if_is_branch,
   input  logic              upd_valid,
   input  logic [31:0]       upd_pc,
   input  logic              upd_taken,
   input  logic              upd_pdt_res,
   input  logic              upd_which_pdt,
   input  logic [HIST_W-1:0] upd_history,
   output logic              pdt_res_o,
   output logic              which_pdt_o,
   output logic [HIST_W-1:0] history_o,
   output logic              init_done_o
);

`ifdef BPD_TOURNAMENT_EN
   localparam int INIT_W = (HIST_W > LIDX_W) ? HIST_W : LIDX_W;
`else
   localparam int INIT_W = LIDX_W;
`endif

   pdt_state_e        state_q, state_d;
   logic [INIT_W-1:0] init_idx_q, init_idx_d;
   logic              in_run;
   logic              upd_en;
   logic [LIDX_W-1:0] l_rd_idx, l_upd_idx;
   logic [1:0]        l_rd_cnt, l_upd_cnt;
   logic              unused_bits;

   assign in_run      = (state_q == ST_RUN);
   assign upd_en      = upd_valid && in_run;
   assign l_rd_idx    = if_pc[LIDX_W+1:2];
   assign l_upd_idx   = upd_pc[LIDX_W+1:2];
   assign init_done_o = in_run;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      case (state_q)
         ST_INIT: begin
            init_idx_d = init_idx_q + INIT_W'(1);
            if (init_idx_q == '1) state_d = ST_RUN;
         end
         default: ;
      endcase
   end

   pdt_table #(.IDX_W(LIDX_W), .INIT_W(INIT_W)) u_lpht (
      .clk        (clk),
      .rd_idx_i   (l_rd_idx),
      .rd_cnt_o   (l_rd_cnt),
      .upd_en_i   (upd_en),
      .upd_idx_i  (l_upd_idx),
      .upd_inc_i  (upd_taken),
      .upd_cnt_o  (l_upd_cnt),
      .init_en_i  (!in_run),
      .init_idx_i (init_idx_q)
   );

`ifdef BPD_TOURNAMENT_EN
   logic [HIST_W-1:0] ghr_q, ghr_d;
   logic [HIST_W-1:0] g_rd_idx, g_upd_idx;
   logic [1:0]        g_rd_cnt, g_upd_cnt, c_rd_cnt, c_upd_cnt_unused;
   logic              lc_ok, gc_ok, c_upd_en;

   assign g_rd_idx  = ghr_q ^ if_pc[HIST_W+1:2];
   assign g_upd_idx = upd_history ^ upd_pc[HIST_W+1:2];

   // Chooser only learns when exactly one component was right, judged on pre-update counters.
   assign lc_ok    = (l_upd_cnt[1] == upd_taken);
   assign gc_ok    = (g_upd_cnt[1] == upd_taken);
   assign c_upd_en = upd_en && (lc_ok != gc_ok);

   pdt_table #(.IDX_W(HIST_W), .INIT_W(INIT_W)) u_gpht (
      .clk        (clk),
      .rd_idx_i   (g_rd_idx),
      .rd_cnt_o   (g_rd_cnt),
      .upd_en_i   (upd_en),
      .upd_idx_i  (g_upd_idx),
      .upd_inc_i  (upd_taken),
      .upd_cnt_o  (g_upd_cnt),
      .init_en_i  (!in_run),
      .init_idx_i (init_idx_q)
   );

   pdt_table #(.IDX_W(LIDX_W), .INIT_W(INIT_W)) u_chooser (
      .clk        (clk),
      .rd_idx_i   (l_rd_idx),
      .rd_cnt_o   (c_rd_cnt),
      .upd_en_i   (c_upd_en),
      .upd_idx_i  (l_upd_idx),
      .upd_inc_i  (gc_ok),
      .upd_cnt_o  (c_upd_cnt_unused),
      .init_en_i  (!in_run),
      .init_idx_i (init_idx_q)
   );

   always_ff @(posedge clk) begin
      if (rst) ghr_q <= '0;
      else     ghr_q <= ghr_d;
   end

   always_comb begin
      pdt_res_o   = 1'b0;
      which_pdt_o = 1'b0;
      history_o   = '0;
      ghr_d       = '0;
      if (in_run) begin
         which_pdt_o = c_rd_cnt[1];
         pdt_res_o   = c_rd_cnt[1] ? g_rd_cnt[1] : l_rd_cnt[1];
         history_o   = ghr_q;
         ghr_d       = ghr_q;
         // A misprediction restore outranks the speculative shift of the current fetch.
         if (upd_valid && (upd_taken != upd_pdt_res)) begin
            ghr_d = {upd_history[HIST_W-2:0], upd_taken};
         end else if (if_is_branch && !stall[0]) begin
            ghr_d = {ghr_q[HIST_W-2:0], pdt_res_o};
         end
      end
   end

   assign unused_bits = ^{stall, if_pc, upd_pc, upd_which_pdt, c_upd_cnt_unused};
`else
   always_comb begin
      pdt_res_o   = 1'b0;
      which_pdt_o = 1'b0;
      history_o   = '0;
      if (in_run) pdt_res_o = l_rd_cnt[1];
   end

   assign unused_bits = ^{stall, if_pc, upd_pc, if_is_branch, upd_pdt_res,
                          upd_which_pdt, upd_history, l_upd_cnt};
`endif

endmodule

// File: tb/tb_branch_pdt.sv
// Scoreboard bench for branch_pdt: a behavioural predictor model pushes expected lookups, a negedge monitor pops them.
// Directed spot checks cover init timing, local training, history shifting/restore, chooser learning and mid-run reset.
`timescale 1ns/1ps
module tb_branch_pdt;

   localparam int HIST_W = 10;
   localparam int LIDX_W = 10;
`ifdef BPD_TOURNAMENT_EN
   localparam int INIT_N = 1 << ((HIST_W > LIDX_W) ? HIST_W : LIDX_W);
`else
   localparam int INIT_N = 1 << LIDX_W;
`endif

   logic              clk, rst;
   logic [5:0]        stall;
   logic [31:0]       if_pc, upd_pc;
   logic              if_is_branch, upd_valid, upd_taken, upd_pdt_res, upd_which_pdt;
   logic [HIST_W-1:0] upd_history;
   logic              pdt_res_o, which_pdt_o, init_done_o;
   logic [HIST_W-1:0] history_o;

   branch_pdt #(.HIST_W(HIST_W), .LIDX_W(LIDX_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .if_pc         (if_pc),
      .if_is_branch  (if_is_branch),
      .upd_valid     (upd_valid),
      .upd_pc        (upd_pc),
      .upd_taken     (upd_taken),
      .upd_pdt_res   (upd_pdt_res),
      .upd_which_pdt (upd_which_pdt),
      .upd_history   (upd_history),
      .pdt_res_o     (pdt_res_o),
      .which_pdt_o   (which_pdt_o),
      .history_o     (history_o),
      .init_done_o   (init_done_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic              pdt;
      logic              which;
      logic [HIST_W-1:0] hist;
      logic              done;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         chk("sb_pdt_res",   32'(pdt_res_o),   32'(e.pdt));
         chk("sb_which_pdt", 32'(which_pdt_o), 32'(e.which));
         chk("sb_history",   32'(history_o),   32'(e.hist));
         chk("sb_init_done", 32'(init_done_o), 32'(e.done));
      end
   end

   // Reference model state
   logic [1:0]        m_lpht [1 << LIDX_W];
`ifdef BPD_TOURNAMENT_EN
   logic [1:0]        m_gpht [1 << HIST_W];
   logic [1:0]        m_chs  [1 << LIDX_W];
   logic [HIST_W-1:0] m_ghr;
`endif
   int                m_init_left;

   function automatic logic [1:0] sat(input logic [1:0] c, input logic up);
      if (up) return (c == 2'b11) ? c : c + 2'b01;
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < (1 << LIDX_W); i++) m_lpht[i] = 2'b01;
`ifdef BPD_TOURNAMENT_EN
      for (int i = 0; i < (1 << HIST_W); i++) m_gpht[i] = 2'b01;
      for (int i = 0; i < (1 << LIDX_W); i++) m_chs[i] = 2'b01;
      m_ghr = '0;
`endif
      m_init_left = INIT_N;
   endtask

   task automatic step(input logic r, input logic [31:0] pc, input logic br, input logic st0,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic upr,
                       input logic [HIST_W-1:0] uh);
      exp_t              e;
      logic [LIDX_W-1:0] li, uli;
      logic [1:0]        lc;
`ifdef BPD_TOURNAMENT_EN
      logic [HIST_W-1:0] ugi;
      logic [1:0]        gc;
      logic              lok, gok;
`endif
      @(posedge clk);
      #1;
      rst = r;  if_pc = pc;  if_is_branch = br;  stall = {5'($urandom), st0};
      upd_valid = uv;  upd_pc = upc;  upd_taken = ut;  upd_pdt_res = upr;
      upd_history = uh;  upd_which_pdt = 1'($urandom);
      if (r) begin
         model_reset();
         return;
      end
      if (m_init_left > 0) begin
         e = '0;
         sbq.push_back(e);
         m_init_left--;
         return;
      end
      li = pc[LIDX_W+1:2];
      e.done = 1'b1;
`ifdef BPD_TOURNAMENT_EN
      e.which = m_chs[li][1];
      e.pdt   = e.which ? m_gpht[m_ghr ^ pc[HIST_W+1:2]][1] : m_lpht[li][1];
      e.hist  = m_ghr;
`else
      e.which = 1'b0;
      e.pdt   = m_lpht[li][1];
      e.hist  = '0;
`endif
      sbq.push_back(e);
      if (uv) begin
         uli = upc[LIDX_W+1:2];
         lc  = m_lpht[uli];
         m_lpht[uli] = sat(lc, ut);
`ifdef BPD_TOURNAMENT_EN
         ugi = uh ^ upc[HIST_W+1:2];
         gc  = m_gpht[ugi];
         m_gpht[ugi] = sat(gc, ut);
         lok = (lc[1] == ut);
         gok = (gc[1] == ut);
         if (lok != gok) m_chs[uli] = sat(m_chs[uli], gok);
`endif
      end
`ifdef BPD_TOURNAMENT_EN
      if (uv && (ut != upr))     m_ghr = {uh[HIST_W-2:0], ut};
      else if (br && !st0)       m_ghr = {m_ghr[HIST_W-2:0], e.pdt};
`endif
   endtask

   task automatic look(input logic [31:0] pc, input logic br, input logic st0);
      step(1'b0, pc, br, st0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
   endtask

   task automatic upd(input logic [31:0] pc, input logic ut, input logic upr, input logic [HIST_W-1:0] uh);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, pc, ut, upr, uh);
   endtask

   // Reset pulse followed by the whole init sweep with garbage traffic that must be ignored.
   task automatic do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
      for (int i = 0; i < INIT_N; i++)
         step(1'b0, $urandom, 1'($urandom), 1'($urandom), 1'b1, $urandom,
              1'($urandom), 1'($urandom), HIST_W'($urandom));
   endtask

   logic [31:0]       seq_pc   [4];
   logic [HIST_W-1:0] seq_hist [4];
   logic [31:0]       rpc;

   initial begin
      rst = 1'b1;  stall = '0;  if_pc = '0;  if_is_branch = 1'b0;  upd_valid = 1'b0;
      upd_pc = '0;  upd_taken = 1'b0;  upd_pdt_res = 1'b0;  upd_which_pdt = 1'b0;  upd_history = '0;
      seq_pc   = '{32'h100, 32'h200, 32'h100, 32'h100};
      seq_hist = '{10'h000, 10'h001, 10'h002, 10'h005};
      model_reset();

      do_reset();
      look(32'h100, 1'b0, 1'b0);
      @(negedge clk);
      chk("first_init_done", 32'(init_done_o), 32'd1);
      chk("first_pdt",       32'(pdt_res_o),   32'd0);
      chk("first_which",     32'(which_pdt_o), 32'd0);

      // Local training at 0x100: 01 -> 10 -> 11 -> 11
      for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 1'b0, '0);
      look(32'h100, 1'b0, 1'b0);
      @(negedge clk);
      chk("lpht_trained", 32'(pdt_res_o), 32'd1);

      // Restore the history to zero through a mispredict with a zero snapshot.
      upd(32'h3000, 1'b0, 1'b1, '0);
      for (int i = 0; i < 4; i++) begin
         look(seq_pc[i], 1'b1, 1'b0);
`ifdef BPD_TOURNAMENT_EN
         @(negedge clk);
         chk("hist_shift", 32'(history_o), 32'(seq_hist[i]));
`endif
      end
      look(32'h100, 1'b1, 1'b1);
`ifdef BPD_TOURNAMENT_EN
      @(negedge clk);
      chk("hist_before_stall", 32'(history_o), 32'h00B);
`endif
      look(32'h100, 1'b0, 1'b0);
`ifdef BPD_TOURNAMENT_EN
      @(negedge clk);
      chk("hist_stall_hold", 32'(history_o), 32'h00B);
`endif

      step(1'b0, 32'h100, 1'b1, 1'b0, 1'b1, 32'h800, 1'b1, 1'b0, 10'h155);
      look(32'h100, 1'b0, 1'b0);
`ifdef BPD_TOURNAMENT_EN
      @(negedge clk);
      chk("hist_restore", 32'(history_o), 32'h2AB);
`endif

      // Chooser learning at 0x400: saturate local taken, then let global win twice.
      for (int i = 0; i < 3; i++) upd(32'h400, 1'b1, 1'b1, 10'h000);
      for (int i = 0; i < 2; i++) upd(32'h400, 1'b0, 1'b0, 10'h3FF);
      look(32'h400, 1'b0, 1'b0);
`ifdef BPD_TOURNAMENT_EN
      @(negedge clk);
      chk("chooser_global", 32'(which_pdt_o), 32'd1);
`endif
      upd(32'h400, 1'b0, 1'b0, 10'h3FF);
      upd(32'h400, 1'b0, 1'b0, 10'h000);
      look(32'h400, 1'b0, 1'b0);
`ifdef BPD_TOURNAMENT_EN
      @(negedge clk);
      chk("chooser_both_ok_hold", 32'(which_pdt_o), 32'd1);
`endif
      upd(32'h400, 1'b0, 1'b0, 10'h000);
      look(32'h400, 1'b0, 1'b0);
      @(negedge clk);
      chk("chooser_back_local", 32'(which_pdt_o), 32'd0);

      // Mixed traffic over a few colliding PCs, including same-entry lookup and update.
      for (int i = 0; i < 300; i++) begin
         rpc = {22'h0, 4'($urandom), 6'h0};
         step(1'b0, rpc, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
              (i % 3 == 0) ? rpc : {22'h0, 4'($urandom), 6'h0},
              1'($urandom), 1'($urandom), HIST_W'($urandom_range(0, 7)));
      end

      // Retrain 0x100 then reset mid-run: the trained entry must be forgotten.
      for (int i = 0; i < 3; i++) upd(32'h100, 1'b1, 1'b1, '0);
      look(32'h100, 1'b0, 1'b0);
      @(negedge clk);
      chk("pre_rst_pdt", 32'(pdt_res_o), 32'd1);
      do_reset();
      look(32'h100, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_rst_done", 32'(init_done_o), 32'd1);
      chk("post_rst_pdt",  32'(pdt_res_o),   32'd0);

      @(posedge clk);
      #1;
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_pdt.md
# branch_pdt

Fetch-stage tournament branch predictor, directly upstream of the IF/ID pipeline register. For every fetched PC it produces the taken/not-taken prediction, the selected component and the global-history snapshot that IF/ID carries to decode and execute. It also keeps the predictor tables up to date from resolved branches returned by EX, and restores the global history on a misprediction.

## Interface
Parameters:
- HIST_W, 10: global history width; the gshare table has 2^HIST_W entries.
- LIDX_W, 10: local and chooser table index width; PC bits [LIDX_W+1:2].

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- stall, input, 6: pipeline stall vector. stall[0]=1 freezes speculative history.
- if_pc, input, 32: current fetch PC.
- if_is_branch, input, 1: pre-decode flag; the fetched instruction is a conditional branch.
- upd_valid, input, 1: EX resolved a conditional branch this cycle.
- upd_pc, input, 32: PC of the resolved branch.
- upd_taken, input, 1: actual outcome.
- upd_pdt_res, input, 1: prediction carried down the pipe.
- upd_which_pdt, input, 1: component used for that prediction (1 = global).
- upd_history, input, HIST_W: history snapshot carried down the pipe.
- pdt_res_o, output, 1: prediction for if_pc (1 = taken).
- which_pdt_o, output, 1: component selected (1 = global, 0 = local).
- history_o, output, HIST_W: GHR value used for this lookup.
- init_done_o, output, 1: table initialisation complete.

## Operation
- Counter encoding: 2-bit saturating; 00 SNT, 01 WNT, 10 WT, 11 ST. Bit 1 is the prediction. Increment saturates at 11; decrement saturates at 00.
- Tables:
  - LPHT[2^LIDX_W], indexed if_pc[LIDX_W+1:2].
  - GPHT[2^HIST_W], indexed ghr ^ if_pc[HIST_W+1:2].
  - CHOOSER[2^LIDX_W], indexed like LPHT. Bit 1 = 1 selects global.
- Lookup is combinational:
  - which_pdt_o = CHOOSER[1].
  - pdt_res_o = which_pdt_o ? GPHT[1] : LPHT[1].
  - history_o = ghr.
- FSM has two states, INIT and RUN.
  - rst forces INIT with init_idx = 0, at any time, including mid-operation.
  - INIT writes 01 into every table at index init_idx, then increments init_idx. Entries beyond a smaller table's size are ignored.
  - When init_idx = 2^max(HIST_W,LIDX_W) - 1 is written, the FSM moves to RUN.
  - In INIT: pdt_res_o = 0, which_pdt_o = 0, history_o = 0, init_done_o = 0, ghr held at 0, and upd_valid is ignored.
- GHR rules in RUN, highest priority first:
  1. upd_valid && upd_taken != upd_pdt_res: ghr <= {upd_history[HIST_W-2:0], upd_taken}.
  2. if_is_branch && !stall[0]: ghr <= {ghr[HIST_W-2:0], pdt_res_o}.
  3. Otherwise ghr holds.
- Table update in RUN on upd_valid:
  - LPHT[upd_pc idx] moves toward upd_taken.
  - GPHT[upd_history ^ upd_pc idx] moves toward upd_taken.
  - Chooser: re-read both component counters (pre-update values) as lc and gc. If (lc[1]==upd_taken) != (gc[1]==upd_taken), CHOOSER[idx] increments when global is correct and decrements when local is correct. Otherwise it holds.
- Same-cycle lookup and update of one entry: lookup returns the old value; the write is visible next cycle.

## Timing
- Prediction outputs are zero-latency (combinational from if_pc and state). IF/ID registers them.
- Table and GHR writes take effect at the next posedge.
- Initialisation takes exactly 2^max(HIST_W,LIDX_W) cycles after rst deasserts: 1024 at defaults. init_done_o rises on the first RUN cycle.
- There is no back-pressure on the update port. One update per cycle is accepted.

## Configuration
- BPD_TOURNAMENT_EN defined: full tournament behaviour as above.
- Undefined:
  - GPHT, CHOOSER and ghr are not built.
  - which_pdt_o = 0, history_o = 0, pdt_res_o = LPHT[1].
  - upd_history and upd_which_pdt are ignored.
  - INIT lasts 2^LIDX_W cycles.

## Structure
- The shared defines file holds: the counter encodings (SNT/WNT/WT/ST), the default HIST_W/LIDX_W, and the FSM state codes.
- One sub-module, pdt_table: a parameterised-depth 2-bit counter array with one combinational read port, one saturating-update port and one init-write port. It is instantiated three times, or once without BPD_TOURNAMENT_EN.

## Test plan
- Reset then wait: init_done_o = 0 for 1024 cycles, then 1. Outputs are 0 throughout INIT. The first lookup of any PC gives pdt_res_o = 0 and which_pdt_o = 0.
- Three taken updates on upd_pc = 0x100 with a local prediction: LPHT goes 01->10->11->11. A lookup at 0x100 then gives pdt_res_o = 1.
- if_is_branch = 1 for 4 cycles with predictions 1,0,1,1 and stall[0] = 0: history_o steps 0x000->0x001->0x002->0x005->0x00B. With stall[0] = 1, history holds.
- Mispredict with upd_history = 0x155 and upd_taken = 1, at the same time as if_is_branch: the next history_o is 0x2AB, so the restore wins.
- Global correct and local wrong on the same PC, twice: CHOOSER goes 01->10->11 and which_pdt_o becomes 1. Both correct leaves the chooser unchanged.
- Assert rst mid-RUN after training: INIT restarts, and afterwards the trained PC predicts 0 again.
